fetch_8085_pipeline: RTL and testbench

Instruction-fetch stage placed directly upstream of the decode stage of the 8085 pipelined processor. It reads program bytes from a synchronous program memory, assembles 1-, 2- and 3-byte 8085 instructions, and delivers each complete instruction to decode over a valid/ready handshake. It also handles redirects (jump, call, return) and stops after `HLT`.

---
 rtl/fetch_8085_pipeline_pkg.sv | 23 ++
 rtl/fetch_8085_pipeline_if.sv | 37 +++
 rtl/fetch_8085_pipeline_inst_len.sv | 33 +++
 rtl/fetch_8085_pipeline.sv | 139 +++++++++++++
 tb/tb_fetch_8085_pipeline.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_8085_pipeline_pkg.sv
// +--------------------------------------------------------------------+
// | pkg_8085 : shared capture-state encodings and length constants   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

package pkg_8085;

   typedef enum logic [1:0] {
      CAP_OPC = 2'd0,
      CAP_B2  = 2'd1,
      CAP_B3  = 2'd2
   } cap_state_t;

   localparam logic [7:0] OPC_HLT = 8'h76;

   localparam logic [1:0] LEN_1 = 2'd1;
   localparam logic [1:0] LEN_2 = 2'd2;
   localparam logic [1:0] LEN_3 = 2'd3;

endpackage

`default_nettype wire

// File: rtl/fetch_8085_pipeline_if.sv
// +--------------------------------------------------------------------+
// | fetch_8085_pipeline_if : program-memory, decode and redirect bus  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

interface fetch_8085_pipeline_if;

   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_data;
   logic        if_valid;
   logic [7:0]  if_opcode;
   logic [7:0]  if_byte2;
   logic [7:0]  if_byte3;
   logic [1:0]  if_len;
   logic [15:0] if_pc;
   logic        dec_ready;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        halted;

   modport master (
      output mem_addr, mem_rd, if_valid, if_opcode, if_byte2, if_byte3,
             if_len, if_pc, halted,
      input  mem_data, dec_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  mem_addr, mem_rd, if_valid, if_opcode, if_byte2, if_byte3,
             if_len, if_pc, halted,
      output mem_data, dec_ready, redirect_valid, redirect_pc
   );

endinterface

`default_nettype wire

// File: rtl/fetch_8085_pipeline_inst_len.sv
// +--------------------------------------------------------------------+
// | inst_len_8085 : 8085 opcode to instruction length (1..3)          |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module inst_len_8085
   import pkg_8085::*;
(
   input  logic [7:0] opcode,
   output logic [1:0] len
);

   always_comb begin
      len = LEN_1;
      case (opcode)
         8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
         8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
         8'hD3, 8'hDB:
            len = LEN_2;
         8'h01, 8'h11, 8'h21, 8'h31, 8'h22, 8'h2A, 8'h32, 8'h3A,
         8'hC3, 8'hC2, 8'hCA, 8'hD2, 8'hDA, 8'hE2, 8'hEA, 8'hF2,
         8'hFA, 8'hCD, 8'hC4, 8'hCC, 8'hD4, 8'hDC, 8'hE4, 8'hEC,
         8'hF4, 8'hFC:
            len = LEN_3;
         default:
            len = LEN_1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/fetch_8085_pipeline.sv
// +--------------------------------------------------------------------+
// | fetch_8085_pipeline : byte-serial 8085 instruction fetch/assembly |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_8085_pipeline
   import pkg_8085::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic                  clk,
   input  logic                  rst,
   fetch_8085_pipeline_if.master bus
);

   cap_state_t  state;
   logic [15:0] fpc;
   logic        rd_pend;
   logic        ib_done;
   logic [7:0]  ib_opc;
   logic [7:0]  ib_b2;
   logic [7:0]  ib_b3;
   logic [1:0]  ib_len;
   logic [15:0] ib_pc;

   logic [1:0]  new_len;
   logic        out_free;
   logic        final_cap;
   logic        hlt_cap;
   logic        rd;
   logic [7:0]  asm_opc;
   logic [7:0]  asm_b2;
   logic [7:0]  asm_b3;
   logic [1:0]  asm_len;
   logic [15:0] asm_pc;

   inst_len_8085 u_len (
      .opcode (bus.mem_data),
      .len    (new_len)
   );

   assign out_free  = ~bus.if_valid | bus.dec_ready;
   assign final_cap = rd_pend & (((state == CAP_OPC) & (new_len == LEN_1)) |
                                 ((state == CAP_B2)  & (ib_len == LEN_2))  |
                                  (state == CAP_B3));
   assign hlt_cap   = rd_pend & (state == CAP_OPC) & (bus.mem_data == OPC_HLT);

   // A read is only issued when the byte it returns is guaranteed a slot.
   assign rd = ~rst & ~bus.halted & ~bus.redirect_valid & ~ib_done &
               ~(final_cap & ~out_free) & ~hlt_cap;

   assign bus.mem_rd   = rd;
   assign bus.mem_addr = fpc;

   // Bundle as it looks with this cycle's returned byte merged in.
   always_comb begin
      asm_opc = ib_opc;
      asm_b2  = ib_b2;
      asm_b3  = ib_b3;
      asm_len = ib_len;
      asm_pc  = ib_pc;
      case (state)
         CAP_OPC: begin
            asm_opc = bus.mem_data;
            asm_b2  = 8'h00;
            asm_b3  = 8'h00;
            asm_len = new_len;
            asm_pc  = fpc - 16'd1;
         end
         CAP_B2:  asm_b2 = bus.mem_data;
         CAP_B3:  asm_b3 = bus.mem_data;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || bus.redirect_valid) begin
         state         <= CAP_OPC;
         fpc           <= rst ? RESET_PC : bus.redirect_pc;
         rd_pend       <= 1'b0;
         ib_done       <= 1'b0;
         ib_opc        <= 8'h00;
         ib_b2         <= 8'h00;
         ib_b3         <= 8'h00;
         ib_len        <= 2'd0;
         ib_pc         <= 16'h0000;
         bus.if_valid  <= 1'b0;
         bus.halted    <= 1'b0;
         if (rst) begin
            bus.if_opcode <= 8'h00;
            bus.if_byte2  <= 8'h00;
            bus.if_byte3  <= 8'h00;
            bus.if_len    <= 2'd0;
            bus.if_pc     <= 16'h0000;
         end
      end else begin
         rd_pend <= rd;
         if (rd)
            fpc <= fpc + 16'd1;
         if (hlt_cap)
            bus.halted <= 1'b1;
         if (rd_pend) begin
            ib_opc <= asm_opc;
            ib_b2  <= asm_b2;
            ib_b3  <= asm_b3;
            ib_len <= asm_len;
            ib_pc  <= asm_pc;
            if (final_cap)
               state <= CAP_OPC;
            else
               state <= (state == CAP_OPC) ? CAP_B2 : CAP_B3;
         end
         if (final_cap && out_free) begin
            bus.if_valid  <= 1'b1;
            bus.if_opcode <= asm_opc;
            bus.if_byte2  <= asm_b2;
            bus.if_byte3  <= asm_b3;
            bus.if_len    <= asm_len;
            bus.if_pc     <= asm_pc;
         end else if (final_cap) begin
            ib_done <= 1'b1;
         end else if (ib_done && out_free) begin
            ib_done       <= 1'b0;
            bus.if_valid  <= 1'b1;
            bus.if_opcode <= ib_opc;
            bus.if_byte2  <= ib_b2;
            bus.if_byte3  <= ib_b3;
            bus.if_len    <= ib_len;
            bus.if_pc     <= ib_pc;
         end else if (bus.dec_ready) begin
            bus.if_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_8085_pipeline.sv
// +--------------------------------------------------------------------+
// | tb_fetch_8085_pipeline : directed self-checking bench for fetch   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_fetch_8085_pipeline;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_pass;

   logic [7:0]  mem [65536];
   logic [15:0] got [$];

   fetch_8085_pipeline_if bus ();

   fetch_8085_pipeline #(
      .RESET_PC (16'h0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous program memory: data one cycle after the strobe.
   always @(posedge clk)
      if (bus.mem_rd)
         bus.mem_data <= mem[bus.mem_addr];

   task automatic check_eq(input string tag, input logic [31:0] got_v,
                           input logic [31:0] exp_v);
      n_checks++;
      if (got_v !== exp_v)
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got_v, exp_v, cyc);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      cyc++;
   endtask

   task automatic go_to(input int n);
      while (cyc < n) tick();
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
   endtask

   // Leaves the bench inside cycle 0 (first cycle with rst low).
   task automatic do_reset();
      rst                = 1'b1;
      bus.dec_ready      = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 16'h0000;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      cyc = 0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      cyc      = 0;
      bus.mem_data = 8'h00;
      clear_mem();

      // Reset state, observed while rst is still high.
      rst                = 1'b1;
      bus.dec_ready      = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 16'h0000;
      repeat (3) @(posedge clk);
      #2;
      check_eq("rst_valid",  32'(bus.if_valid), 32'h0);
      check_eq("rst_halted", 32'(bus.halted),   32'h0);
      check_eq("rst_len",    32'(bus.if_len),   32'h0);
      check_eq("rst_pc",     32'(bus.if_pc),    32'h0);
      check_eq("rst_mem_rd", 32'(bus.mem_rd),   32'h0);

      // 2-byte MVI A followed by 1-byte ADD B.
      clear_mem();
      mem[0] = 8'h3E; mem[1] = 8'h05; mem[2] = 8'h80;
      do_reset();
      check_eq("c0_mem_rd",   32'(bus.mem_rd),   32'h1);
      check_eq("c0_mem_addr", 32'(bus.mem_addr), 32'h0000);
      go_to(3);
      check_eq("mvi_valid", 32'(bus.if_valid),  32'h1);
      check_eq("mvi_opc",   32'(bus.if_opcode), 32'h3E);
      check_eq("mvi_b2",    32'(bus.if_byte2),  32'h05);
      check_eq("mvi_b3",    32'(bus.if_byte3),  32'h00);
      check_eq("mvi_len",   32'(bus.if_len),    32'h2);
      check_eq("mvi_pc",    32'(bus.if_pc),     32'h0000);
      go_to(4);
      check_eq("add_valid", 32'(bus.if_valid),  32'h1);
      check_eq("add_opc",   32'(bus.if_opcode), 32'h80);
      check_eq("add_len",   32'(bus.if_len),    32'h1);
      check_eq("add_pc",    32'(bus.if_pc),     32'h0002);

      // 3-byte JMP 1234.
      clear_mem();
      mem[0] = 8'hC3; mem[1] = 8'h34; mem[2] = 8'h12;
      do_reset();
      go_to(3);
      check_eq("jmp_addr_c3", 32'(bus.mem_addr), 32'h0003);
      check_eq("jmp_nv_c3",   32'(bus.if_valid), 32'h0);
      go_to(4);
      check_eq("jmp_valid", 32'(bus.if_valid),  32'h1);
      check_eq("jmp_opc",   32'(bus.if_opcode), 32'hC3);
      check_eq("jmp_len",   32'(bus.if_len),    32'h3);
      check_eq("jmp_b2",    32'(bus.if_byte2),  32'h34);
      check_eq("jmp_b3",    32'(bus.if_byte3),  32'h12);
      check_eq("jmp_pc",    32'(bus.if_pc),     32'h0000);

      // Backpressure on a stream of NOPs: nothing dropped.
      clear_mem();
      do_reset();
      go_to(2);
      bus.dec_ready = 1'b0;
      check_eq("bp_c2_valid", 32'(bus.if_valid), 32'h1);
      check_eq("bp_c2_pc",    32'(bus.if_pc),    32'h0000);
      go_to(5);
      check_eq("bp_c5_mem_rd", 32'(bus.mem_rd),  32'h0);
      check_eq("bp_c5_pc",     32'(bus.if_pc),   32'h0000);
      go_to(8);
      check_eq("bp_c8_valid", 32'(bus.if_valid), 32'h1);
      check_eq("bp_c8_pc",    32'(bus.if_pc),    32'h0000);
      go_to(9);
      bus.dec_ready = 1'b1;
      #1;
      got.delete();
      for (int c = 0; c < 30 && got.size() < 4; c++) begin
         if (bus.if_valid && bus.dec_ready) got.push_back(bus.if_pc);
         tick();
      end
      for (int i = 0; i < 4; i++)
         check_eq($sformatf("bp_seq%0d", i),
                  (i < got.size()) ? 32'(got[i]) : 32'hDEAD_BEEF, 32'(i));

      // Redirect mid-way through a 3-byte fetch.
      clear_mem();
      mem[0] = 8'hC3; mem[1] = 8'h34; mem[2] = 8'h12;
      do_reset();
      go_to(2);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 16'h0100;
      #1;
      check_eq("rd_c2_mem_rd", 32'(bus.mem_rd), 32'h0);
      go_to(3);
      bus.redirect_valid = 1'b0;
      #1;
      check_eq("rd_c3_addr",  32'(bus.mem_addr), 32'h0100);
      check_eq("rd_c3_rd",    32'(bus.mem_rd),   32'h1);
      check_eq("rd_c3_valid", 32'(bus.if_valid), 32'h0);
      go_to(4);
      check_eq("rd_c4_valid", 32'(bus.if_valid), 32'h0);
      go_to(5);
      check_eq("rd_c5_valid", 32'(bus.if_valid),  32'h1);
      check_eq("rd_c5_pc",    32'(bus.if_pc),     32'h0100);
      check_eq("rd_c5_len",   32'(bus.if_len),    32'h1);

      // HLT at 0005, then a redirect wakes fetch at 0010.
      clear_mem();
      mem[5] = 8'h76;
      do_reset();
      go_to(7);
      check_eq("hlt_valid",  32'(bus.if_valid),  32'h1);
      check_eq("hlt_opc",    32'(bus.if_opcode), 32'h76);
      check_eq("hlt_pc",     32'(bus.if_pc),     32'h0005);
      check_eq("hlt_len",    32'(bus.if_len),    32'h1);
      check_eq("hlt_halted", 32'(bus.halted),    32'h1);
      go_to(12);
      check_eq("hlt_c12_rd",   32'(bus.mem_rd),   32'h0);
      check_eq("hlt_c12_addr", 32'(bus.mem_addr), 32'h0006);
      check_eq("hlt_c12_hlt",  32'(bus.halted),   32'h1);
      check_eq("hlt_c12_nv",   32'(bus.if_valid), 32'h0);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 16'h0010;
      go_to(13);
      bus.redirect_valid = 1'b0;
      #1;
      check_eq("wake_halted", 32'(bus.halted),   32'h0);
      check_eq("wake_rd",     32'(bus.mem_rd),   32'h1);
      check_eq("wake_addr",   32'(bus.mem_addr), 32'h0010);
      go_to(15);
      check_eq("wake_valid", 32'(bus.if_valid), 32'h1);
      check_eq("wake_pc",    32'(bus.if_pc),    32'h0010);

      // Instruction spanning the FFFF -> 0000 wrap.
      clear_mem();
      mem[16'hFFFF] = 8'h3E; mem[0] = 8'h07;
      do_reset();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 16'hFFFF;
      go_to(1);
      bus.redirect_valid = 1'b0;
      #1;
      check_eq("wrap_c1_addr", 32'(bus.mem_addr), 32'hFFFF);
      go_to(3);
      check_eq("wrap_c3_addr", 32'(bus.mem_addr), 32'h0001);
      check_eq("wrap_c3_rd",   32'(bus.mem_rd),   32'h1);
      go_to(4);
      check_eq("wrap_valid", 32'(bus.if_valid),  32'h1);
      check_eq("wrap_pc",    32'(bus.if_pc),     32'hFFFF);
      check_eq("wrap_opc",   32'(bus.if_opcode), 32'h3E);
      check_eq("wrap_b2",    32'(bus.if_byte2),  32'h07);
      check_eq("wrap_len",   32'(bus.if_len),    32'h2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
